// File: rtl/lcd_bus_engine_if.sv
// Request/response handshake between the LCD sequencer and the bus engine.
interface lcd_bus_engine_if;
  logic       start;
  logic       rs;
  logic       rw;
  logic       nibble_only;
  logic       poll_busy;
  logic [7:0] wr_data;
  logic       ready;
  logic       done;
  logic [7:0] rd_data;
  logic       timeout_err;

  modport master (
    output start, rs, rw, nibble_only, poll_busy, wr_data,
    input  ready, done, rd_data, timeout_err
  );

  modport slave (
    input  start, rs, rw, nibble_only, poll_busy, wr_data,
    output ready, done, rd_data, timeout_err
  );
endinterface

// File: rtl/lcd_bus_engine.sv
// HD44780 bus transfer engine: 4/8-bit byte writes/reads, single-nibble writes,
// and optional busy-flag polling with a timeout after a write.
module lcd_bus_engine #(
  parameter int BUS_WIDTH    = 4,
  parameter int T_SETUP      = 50,
  parameter int T_EHIGH      = 150,
  parameter int T_HOLD       = 50,
  parameter int BUSY_TIMEOUT = 250000,
  parameter int TMR_W        = 21
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  lcd_bus_engine_if.slave      req,
  inout  wire  [BUS_WIDTH-1:0] LCD_D,
  output logic                 LCD_RW,
  output logic                 LCD_E,
  output logic                 LCD_RS
);

  typedef enum logic [2:0] {
    IDLE, SETUP, E_HIGH, HOLD, POLL_SETUP, POLL_EHIGH, POLL_HOLD, DONE
  } state_t;

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(T_SETUP - 1);
  localparam logic [TMR_W-1:0] EHIGH_LAST = TMR_W'(T_EHIGH - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(T_HOLD - 1);
  localparam logic [TMR_W-1:0] TO_LIMIT   = TMR_W'(BUSY_TIMEOUT);

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [TMR_W-1:0]     to_q, to_d;
  logic                 beat_q, beat_d;
  logic                 rs_q, rs_d, rw_q, rw_d, nib_q, nib_d, poll_q, poll_d;
  logic [7:0]           wdat_q, wdat_d;
  logic [7:0]           shadow_q, shadow_d;
  logic [7:0]           rd_q, rd_d;
  logic                 err_q, err_d;
  logic                 e_q, e_d, lrw_q, lrw_d, lrs_q, lrs_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;

  logic [TMR_W-1:0]     phase_last;
  logic                 phase_end;
  logic                 last_beat;
  logic                 in_poll;
  logic                 accept;
  logic                 bf;
  logic                 to_hit;
  logic [3:0]           wnib;

  assign accept    = (state_q == IDLE) && req.start;
  assign in_poll   = (state_q == POLL_SETUP) || (state_q == POLL_EHIGH) || (state_q == POLL_HOLD);
  assign bf        = shadow_q[7];
  assign to_hit    = (to_q == TO_LIMIT);
  assign phase_end = (tmr_q == phase_last);
  // Status polls always take both nibbles; nibble_only affects the data phase only.
  assign last_beat = (BUS_WIDTH == 8) || beat_q || (nib_q && !in_poll);
  assign wnib      = (nib_d || beat_d) ? wdat_d[3:0] : wdat_d[7:4];

  always_comb begin
    case (state_q)
      SETUP, POLL_SETUP:  phase_last = SETUP_LAST;
      E_HIGH, POLL_EHIGH: phase_last = EHIGH_LAST;
      default:            phase_last = HOLD_LAST;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      to_q     <= '0;
      beat_q   <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      nib_q    <= 1'b0;
      poll_q   <= 1'b0;
      wdat_q   <= '0;
      shadow_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      e_q      <= 1'b0;
      lrw_q    <= 1'b0;
      lrs_q    <= 1'b0;
      bus_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      to_q     <= to_d;
      beat_q   <= beat_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      nib_q    <= nib_d;
      poll_q   <= poll_d;
      wdat_q   <= wdat_d;
      shadow_q <= shadow_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      e_q      <= e_d;
      lrw_q    <= lrw_d;
      lrs_q    <= lrs_d;
      bus_q    <= bus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (req.start) state_d = SETUP;
      SETUP:      if (phase_end) state_d = E_HIGH;
      E_HIGH:     if (phase_end) state_d = HOLD;
      HOLD: begin
        if (phase_end) begin
          if (!last_beat)          state_d = SETUP;
          else if (!rw_q && poll_q) state_d = POLL_SETUP;
          else                     state_d = DONE;
        end
      end
      POLL_SETUP: if (phase_end) state_d = POLL_EHIGH;
      POLL_EHIGH: if (phase_end) state_d = POLL_HOLD;
      // Timeout is only honoured at a HOLD boundary, so E is never cut short.
      POLL_HOLD: begin
        if (phase_end) begin
          if (to_hit || (last_beat && !bf)) state_d = DONE;
          else                              state_d = POLL_SETUP;
        end
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    tmr_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : tmr_q + 1'b1;

    beat_d = beat_q;
    if (state_q == IDLE)
      beat_d = 1'b0;
    else if ((state_q == HOLD) && (state_d == SETUP))
      beat_d = 1'b1;
    else if ((state_q == HOLD) && (state_d == POLL_SETUP))
      beat_d = 1'b0;
    else if ((state_q == POLL_HOLD) && (state_d == POLL_SETUP))
      beat_d = (BUS_WIDTH == 8) ? 1'b0 : !beat_q;

    to_d = to_q;
    if ((state_q == HOLD) && (state_d == POLL_SETUP))
      to_d = '0;
    else if (in_poll && !to_hit)
      to_d = to_q + 1'b1;

    rs_d   = rs_q;
    rw_d   = rw_q;
    nib_d  = nib_q;
    poll_d = poll_q;
    wdat_d = wdat_q;
    if (accept) begin
      rs_d   = req.rs;
      rw_d   = req.rw;
      nib_d  = req.nibble_only;
      poll_d = req.poll_busy;
      wdat_d = req.wr_data;
    end
  end

  always_comb begin
    e_d      = (state_d == E_HIGH) || (state_d == POLL_EHIGH);
    lrs_d    = lrs_q;
    lrw_d    = lrw_q;
    bus_d    = bus_q;
    shadow_d = shadow_q;
    rd_d     = rd_q;
    err_d    = err_q;

    if ((state_d == SETUP) && (state_q != SETUP)) begin
      lrs_d = rs_d;
      lrw_d = rw_d;
      if (!rw_d)
        bus_d = (BUS_WIDTH == 8) ? BUS_WIDTH'(wdat_d) : BUS_WIDTH'(wnib);
    end

    if ((state_d == POLL_SETUP) && (state_q != POLL_SETUP)) begin
      lrs_d = 1'b0;
      lrw_d = 1'b1;
    end

    // Sample on the last E-high cycle, when LCD output is guaranteed settled.
    if (((state_q == E_HIGH) || (state_q == POLL_EHIGH)) && phase_end && lrw_q) begin
      if (BUS_WIDTH == 8)  shadow_d      = 8'(LCD_D);
      else if (!beat_q)    shadow_d[7:4] = 4'(LCD_D);
      else                 shadow_d[3:0] = 4'(LCD_D);
    end

    if (accept)
      err_d = 1'b0;

    if ((state_d == DONE) && (state_q != DONE)) begin
      lrw_d = 1'b0;
      rd_d  = shadow_q;
      err_d = (state_q == POLL_HOLD) && bf;
    end
  end

  assign LCD_D           = lrw_q ? {BUS_WIDTH{1'bz}} : bus_q;
  assign LCD_E           = e_q;
  assign LCD_RW          = lrw_q;
  assign LCD_RS          = lrs_q;
  assign req.ready       = (state_q == IDLE);
  assign req.done        = (state_q == DONE);
  assign req.rd_data     = rd_q;
  assign req.timeout_err = err_q;

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Directed bench for lcd_bus_engine: a 4-bit instance with a small busy timeout
// and an 8-bit instance, each with a simple HD44780 bus model.
`timescale 1ns/1ps
module tb_lcd_bus_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  lcd_bus_engine_if if4();
  lcd_bus_engine_if if8();

  wire  [3:0] d4;
  wire  [7:0] d8;
  logic       e4, rw4, rs4, e8, rw8, rs8;

  lcd_bus_engine #(.BUS_WIDTH(4), .BUSY_TIMEOUT(2000)) dut4 (
    .CLK(clk), .RST_N(rst_n), .req(if4),
    .LCD_D(d4), .LCD_RW(rw4), .LCD_E(e4), .LCD_RS(rs4)
  );

  lcd_bus_engine #(.BUS_WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .req(if8),
    .LCD_D(d8), .LCD_RW(rw8), .LCD_E(e8), .LCD_RS(rs8)
  );

  // LCD models: 4-bit returns status {BF,010}/{0110}; 8-bit returns A5 while E is high.
  int         bf_polls = 0;
  logic       mdl_clr  = 1'b1;
  logic       m_hi     = 1'b1;
  int         m_polls  = 0;
  logic [3:0] mdl4;
  logic [7:0] mdl8;
  assign mdl4 = m_hi ? {(m_polls < bf_polls), 3'b010} : 4'h6;
  assign mdl8 = e8 ? 8'hA5 : 8'h3C;
  assign d4   = rw4 ? mdl4 : 4'bzzzz;
  assign d8   = rw8 ? mdl8 : 8'hzz;

  int         cyc = 0;
  int         p4 = 0, rb4 = 0, w4 = 0, minw4 = 100000, maxw4 = 0, stab4 = 0, zv4 = 0, dn4 = 0;
  int         p8 = 0, dn8 = 0;
  logic [3:0] pd4 [0:15];
  logic [7:0] pd8 = '0;
  logic       rsr4 = 0, rwr4 = 0, rsr8 = 0, rwr8 = 0;
  logic       e4_p = 0, rs4_p = 0, rw4_p = 0, e8_p = 0;
  logic [3:0] d4_p = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    e4_p  <= e4;
    d4_p  <= d4;
    rs4_p <= rs4;
    rw4_p <= rw4;
    e8_p  <= e8;
    if (mdl_clr) begin
      m_hi <= 1'b1; m_polls <= 0;
      p4 <= 0; rb4 <= 0; w4 <= 0; minw4 <= 100000; maxw4 <= 0;
      stab4 <= 0; zv4 <= 0; dn4 <= 0; p8 <= 0; dn8 <= 0;
      rsr4 <= 1'b0; rwr4 <= 1'b0; rsr8 <= 1'b0; rwr8 <= 1'b0;
    end else begin
      if (!e4 && e4_p && rw4) begin
        m_hi <= !m_hi;
        if (!m_hi) m_polls <= m_polls + 1;
      end
      if (e4 && !e4_p) begin
        p4 <= p4 + 1;
        if (p4 < 16) pd4[p4] <= d4;
        if (rs4) rsr4 <= 1'b1;
        if (rw4) begin rb4 <= rb4 + 1; rwr4 <= 1'b1; end
        w4 <= 1;
      end else if (e4) begin
        w4 <= w4 + 1;
      end
      if (!e4 && e4_p) begin
        if (w4 < minw4) minw4 <= w4;
        if (w4 > maxw4) maxw4 <= w4;
      end
      if (e4 && e4_p && ((d4 !== d4_p) || (rs4 !== rs4_p) || (rw4 !== rw4_p))) stab4 <= stab4 + 1;
      if (rw4 && (d4 !== mdl4)) zv4 <= zv4 + 1;
      if (if4.done) dn4 <= dn4 + 1;
      if (e8 && !e8_p) begin p8 <= p8 + 1; pd8 <= d8; rsr8 <= rs8; rwr8 <= rw8; end
      if (if8.done) dn8 <= dn8 + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  logic rdy_acc;

  task automatic run_txn(input string tag, input bit sel8, input bit rs_, input bit rw_,
                         input bit nib_, input bit pb_, input logic [7:0] wd,
                         input int budget, input int poke_at, output int lat);
    int acc;
    bit seen;
    @(negedge clk);
    mdl_clr = 1'b1;
    if (sel8) begin
      if8.rs = rs_; if8.rw = rw_; if8.nibble_only = nib_; if8.poll_busy = pb_;
      if8.wr_data = wd; if8.start = 1'b1;
    end else begin
      if4.rs = rs_; if4.rw = rw_; if4.nibble_only = nib_; if4.poll_busy = pb_;
      if4.wr_data = wd; if4.start = 1'b1;
    end
    @(posedge clk); #1;
    acc = cyc;
    mdl_clr = 1'b0;
    if4.start = 1'b0;
    if8.start = 1'b0;
    rdy_acc = sel8 ? if8.ready : if4.ready;
    lat = -1;
    seen = 1'b0;
    for (int k = 1; k <= budget && !seen; k++) begin
      if (k == poke_at) begin
        if4.wr_data = 8'hFF; if4.rw = 1'b0; if4.poll_busy = 1'b0; if4.nibble_only = 1'b0;
        if4.start = 1'b1;
      end else begin
        if4.start = 1'b0;
      end
      @(posedge clk); #1;
      if (sel8 ? if8.done : if4.done) begin
        seen = 1'b1;
        lat = cyc - acc;
      end
    end
    if4.start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    if4.start = 0; if4.rs = 0; if4.rw = 0; if4.nibble_only = 0; if4.poll_busy = 0; if4.wr_data = '0;
    if8.start = 0; if8.rs = 0; if8.rw = 0; if8.nibble_only = 0; if8.poll_busy = 0; if8.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e4", e4, 0);
    chk("rst_rw4", rw4, 0);
    chk("rst_rs4", rs4, 0);
    chk("rst_d4", d4, 0);
    chk("rst_ready4", if4.ready, 1);
    chk("rst_done4", if4.done, 0);
    chk("rst_rd4", if4.rd_data, 0);
    chk("rst_terr4", if4.timeout_err, 0);
    chk("rst_e8", e8, 0);
    chk("rst_d8", d8, 0);
    chk("rst_ready8", if8.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4-bit write 0x28, no poll
    run_txn("w28", 0, 0, 0, 0, 0, 8'h28, 1000, -1, lat);
    repeat (3) @(posedge clk); #1;
    chk("w28_ready_after_accept", rdy_acc, 0);
    chk("w28_latency", lat, 500);
    chk("w28_pulses", p4, 2);
    chk("w28_nib0", pd4[0], 4'h2);
    chk("w28_nib1", pd4[1], 4'h8);
    chk("w28_rs_seen", rsr4, 0);
    chk("w28_rw_seen", rwr4, 0);
    chk("w28_min_ehigh", minw4, 150);
    chk("w28_max_ehigh", maxw4, 150);
    chk("w28_stable", stab4, 0);
    chk("w28_terr", if4.timeout_err, 0);
    chk("w28_done_count", dn4, 1);

    // 4-bit write 0x01 with busy poll, BF=1 for 3 polls
    bf_polls = 3;
    run_txn("w01p", 0, 0, 0, 0, 1, 8'h01, 4000, -1, lat);
    chk("w01p_latency", lat, 2500);
    chk("w01p_terr", if4.timeout_err, 0);
    chk("w01p_rd_status", if4.rd_data, 8'h26);
    chk("w01p_rw_after", rw4, 0);
    chk("w01p_bus_after", d4, 4'h1);
    repeat (3) @(posedge clk); #1;
    chk("w01p_pulses", p4, 10);
    chk("w01p_read_beats", rb4, 8);
    chk("w01p_bus_released", zv4, 0);
    chk("w01p_done_count", dn4, 1);
    chk("w01p_stable", stab4, 0);

    // 8-bit read with RS=1
    run_txn("r8", 1, 1, 1, 0, 0, 8'h00, 1000, -1, lat);
    chk("r8_latency", lat, 250);
    chk("r8_rd_data", if8.rd_data, 8'hA5);
    chk("r8_rw_after", rw8, 0);
    repeat (3) @(posedge clk); #1;
    chk("r8_pulses", p8, 1);
    chk("r8_data_at_rise", pd8, 8'hA5);
    chk("r8_rs", rsr8, 1);
    chk("r8_rw", rwr8, 1);
    chk("r8_done_count", dn8, 1);

    // 4-bit single-nibble write
    run_txn("nib", 0, 0, 0, 1, 0, 8'h03, 1000, -1, lat);
    chk("nib_latency", lat, 250);
    repeat (3) @(posedge clk); #1;
    chk("nib_pulses", p4, 1);
    chk("nib_data", pd4[0], 4'h3);

    // BF stuck high, timeout 2000, with an ignored start mid-transaction
    bf_polls = 1000000;
    run_txn("to", 0, 0, 0, 0, 1, 8'h01, 4000, 300, lat);
    chk("to_latency_window", (lat >= 2500) && (lat <= 3000), 1);
    chk("to_terr", if4.timeout_err, 1);
    repeat (700) @(posedge clk); #1;
    chk("to_min_ehigh", minw4, 150);
    chk("to_max_ehigh", maxw4, 150);
    chk("to_done_count", dn4, 1);
    chk("to_ready_idle", if4.ready, 1);
    chk("to_bus_released", zv4, 0);

    // Reset asserted during E high
    @(negedge clk);
    mdl_clr = 1'b1;
    if4.rs = 0; if4.rw = 0; if4.nibble_only = 0; if4.poll_busy = 0; if4.wr_data = 8'h28;
    if4.start = 1'b1;
    @(posedge clk); #1;
    mdl_clr = 1'b0;
    if4.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("rstmid_e_high_before", e4, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_e_low", e4, 0);
    chk("rstmid_ready", if4.ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(posedge clk); #1;
    chk("rstmid_no_done", dn4, 0);
    run_txn("after_rst", 0, 0, 0, 0, 0, 8'h28, 1000, -1, lat);
    chk("after_rst_latency", lat, 500);
    repeat (3) @(posedge clk); #1;
    chk("after_rst_pulses", p4, 2);
    chk("after_rst_nib0", pd4[0], 4'h2);
    chk("after_rst_nib1", pd4[1], 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_engine.md
Name: lcd_bus_engine

Overview:
- Parametrised HD44780 bus transfer engine. Generation after the fixed 4-bit nibble-writer.
- Supports 4-bit or 8-bit bus width, full-byte writes and reads, and single-nibble init writes.
- Optionally polls the busy flag with a timeout after a write.
- Sits between the LCD init/command sequencer and the LCD pins; one transaction at a time.

Parameters:
- BUS_WIDTH, 4, LCD data bus width; legal values 4 or 8.
- T_SETUP, 50, cycles RS/RW/data are stable before E rises (min 1).
- T_EHIGH, 150, cycles E is held high (min 2).
- T_HOLD, 50, cycles after E falls before the next beat or exit (min 1).
- BUSY_TIMEOUT, 250000, maximum poll cycles before aborting (5 ms at 50 MHz).
- TMR_W, 21, timer/timeout counter width; must hold max(T_*, BUSY_TIMEOUT).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- start  in  1  transaction request; accepted only when ready=1
- rs  in  1  register select for the transaction
- rw  in  1  0=write, 1=read
- nibble_only  in  1  4-bit mode only: send wr_data[3:0] as a single beat; ignored when BUS_WIDTH=8
- poll_busy  in  1  after a write, poll the busy flag until clear
- wr_data  in  8  byte to write
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse at transaction end
- rd_data  out  8  read byte; valid when done=1 and held until the next done
- timeout_err  out  1  qualified by done: poll exceeded BUSY_TIMEOUT
- LCD_D  inout  BUS_WIDTH  data bus; driven only while LCD_RW=0, else Z
- LCD_RW  out  1  LCD read/write
- LCD_E  out  1  LCD enable
- LCD_RS  out  1  LCD register select

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST_N.
- Reset values: LCD_E=0, LCD_RW=0, LCD_RS=0, LCD_D driven 0, ready=1, done=0, rd_data=0, timeout_err=0, state=IDLE.
- Reset mid-transaction: LCD_E is 0 at the same edge and no done is issued.
- Outputs: all LCD pin outputs are registered.
- Accepting start: start with ready=1 latches rs, rw, nibble_only, poll_busy and wr_data, then moves to SETUP. start while ready=0 is ignored.
- States: IDLE, SETUP, E_HIGH, HOLD, POLL_SETUP, POLL_EHIGH, POLL_HOLD, DONE.
- Beat timing: each phase lasts exactly its parameter in cycles. The timer clears on phase entry and the phase exits when the timer reaches param-1.
- LCD_E rises on entry to E_HIGH/POLL_EHIGH and falls on exit from it.
- LCD_RS, LCD_RW and LCD_D change only in the SETUP/POLL_SETUP entry cycle, never while E=1.
- Beat count:
  - BUS_WIDTH=8: 1 beat.
  - BUS_WIDTH=4: 2 beats, high nibble first, then low nibble.
  - BUS_WIDTH=4 with nibble_only=1: 1 beat carrying wr_data[3:0].
  - HOLD → SETUP for the next beat; HOLD of the last beat → POLL_SETUP if (rw=0 and poll_busy=1), else DONE.
- Reads: LCD_D is sampled into a shadow register on the last E_HIGH cycle of each beat. Nibbles assemble as {first,second}; in 8-bit mode the byte is sampled directly. rd_data updates on entry to DONE.
- Busy poll:
  - Each poll is one full read transaction with RS=0, RW=1 (2 beats in 4-bit mode, low nibble read and discarded).
  - BF is bit 7 of the status byte.
  - BF=1 → next poll. BF=0 → DONE with timeout_err=0.
- Timeout:
  - A timeout counter clears on entering the first POLL_SETUP and increments every cycle spent polling.
  - On reaching BUSY_TIMEOUT it finishes the current beat's HOLD (E never truncated), then goes to DONE with timeout_err=1.
  - If BF=0 is sampled in the same poll that reaches the limit, success wins.
- DONE: lasts one cycle with done=1, then IDLE. After the transaction LCD_RW returns to 0 and the bus is driven with the last written nibble/byte.
- Throughput: ready rises the cycle after done, so back-to-back transactions have one idle cycle.

Test Plan:
- BUS_WIDTH=4, write rs=0 wr_data=0x28, poll_busy=0 → two E pulses of 150 cycles each, LCD_D=0x2 then 0x8, LCD_RS=0 and LCD_RW=0 throughout. done arrives 500 cycles after start acceptance; timeout_err=0.
- BUS_WIDTH=4, write 0x01 with poll_busy=1; LCD model returns BF=1 for 3 polls, then BF=0 → 3 failing plus 1 passing status reads (8 read beats). LCD_D is Z whenever LCD_RW=1, and done pulses once.
- BUS_WIDTH=8, read rs=1; model drives 0xA5 during E high → single beat, rd_data=0xA5 at done, LCD_RS=1, LCD_RW=1.
- BUS_WIDTH=4, nibble_only=1 wr_data=0x03 → exactly one E pulse with LCD_D=0x3, done 250 cycles after acceptance.
- Poll with BF stuck at 1 and BUSY_TIMEOUT=2000 → done with timeout_err=1 within one poll length after 2000 cycles. E is never shorter than T_EHIGH, and a start issued mid-transaction is ignored.
- Assert RST_N=0 during E_HIGH → LCD_E=0 and ready=1 at that edge; no done. A new write after reset completes normally.
